fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, width of PC and fetch address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of instruction word.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 SHALL have ports: clk input 1 rising-edge clock; rst input 1 asynchronous active-high reset.
REQ-005 SHALL have ports: stall_f input 1 hold PC; stall_d input 1 hold IF/ID register; flush_d input 1 bubble IF/ID register.
REQ-006 SHALL have ports: pc_src_e input 1 taken branch/jump redirect; pc_target_e input ADDRESS_WIDTH redirect address.
REQ-007 SHALL have ports: instr_addr output ADDRESS_WIDTH fetch address to instruction memory; instr_f input DATA_WIDTH combinational instruction returned for instr_addr.
REQ-008 SHALL have ports: instr_d, pc_d, pc_plus4_d outputs (DATA_WIDTH, ADDRESS_WIDTH, ADDRESS_WIDTH) IF/ID register contents; valid_d output 1 IF/ID holds a real instruction.
REQ-009 SHALL have ports: misalign_err output 1 sticky misaligned-redirect flag; fetch_count output 32 count of instructions accepted into IF/ID.

Function
REQ-010 SHALL drive instr_addr directly from the PC register (zero combinational latency); instruction appears on instr_d one clock after its address is presented.
REQ-011 SHALL implement FSM states BOOT, RUN, HALT; BOOT is entered on reset and moves to RUN on the first clock edge with rst low.
REQ-012 SHALL in BOOT keep PC at RESET_PC and load a bubble (instr_d=32'h0000_0013, valid_d=0) into IF/ID.
REQ-013 SHALL in RUN compute next PC with priority: pc_src_e (load pc_target_e) > stall_f (hold) > PC+4.
REQ-014 SHALL compute PC+4 modulo 2^ADDRESS_WIDTH; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no error.
REQ-015 SHALL in RUN update IF/ID with priority: flush_d (bubble) > stall_d (hold all IF/ID fields) > load {instr_f, PC, PC+4, valid=1}.
REQ-016 SHALL, when pc_src_e=1 and pc_target_e[1:0]!=0, not load the PC, set misalign_err=1, bubble IF/ID, and enter HALT on that edge.
REQ-017 SHALL in HALT hold PC, keep IF/ID as bubble with valid_d=0, ignore all inputs, and leave HALT only via rst.
REQ-018 SHALL increment fetch_count by 1 on each edge where IF/ID loads with valid=1; wraps at 2^32; unchanged on stall, flush, BOOT, HALT.
REQ-019 SHALL treat stall_f=1 with stall_d=0 as legal: IF/ID reloads the same PC's instruction (duplicate) unless flush_d=1; sequencing this pair is the hazard unit's responsibility.

Reset
REQ-020 SHALL on rst=1 asynchronously set: PC=RESET_PC, state=BOOT, instr_d=32'h0000_0013, pc_d=0, pc_plus4_d=0, valid_d=0, misalign_err=0, fetch_count=0.
REQ-021 SHALL, when rst asserts mid-operation (including during a stall or HALT), discard all in-flight state; first valid instruction after release is at RESET_PC, two edges after rst deasserts.

Structure
REQ-022 SHALL take NOP encoding (32'h0000_0013), FSM state encoding and RESET_PC default from the shared pipeline package.
REQ-023 SHALL contain one sub-module, if_id_reg, holding instr_d/pc_d/pc_plus4_d/valid_d with en and clr inputs; PC register and FSM reside in fetch_ctrl.
REQ-024 SHALL contain no memory; instruction storage stays in the separate instruction memory fed by instr_addr.

Verification
REQ-025 SHALL cover: reset release, no stalls, instr memory returning addr-derived words -> instr_addr 0,0,4,8; valid_d first 1 at edge 2 with pc_d=0, pc_plus4_d=4; fetch_count=3 after edge 4.
REQ-026 SHALL cover: stall_f=stall_d=1 for 3 cycles at PC=0x10 -> instr_addr stays 0x10, IF/ID unchanged, fetch_count frozen; resumes 0x14 after release.
REQ-027 SHALL cover: pc_src_e=1, pc_target_e=0x100, flush_d=1, stall_f=1 same cycle -> next instr_addr=0x100, instr_d=0x13, valid_d=0.
REQ-028 SHALL cover: pc_src_e=1, pc_target_e=0x102 -> misalign_err=1, PC unchanged, valid_d=0 for 10 following cycles; rst clears misalign_err and restarts at RESET_PC.
REQ-029 SHALL cover: PC forced via redirect to 0xFFFF_FFFC, no stall -> next instr_addr=0x0, pc_plus4_d=0x0 for that instruction, misalign_err=0.
REQ-030 SHALL cover: rst asserted asynchronously between clock edges while stall_d=1 -> all outputs take reset values immediately, before next clk edge.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared pipeline definitions for the fetch stage: NOP encoding, fetch FSM
// state encoding and the default reset PC.
package fetch_ctrl_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // A redirect target is usable only if it lies on a 4-byte boundary.
  function automatic logic word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if_id.sv
// IF/ID pipeline register: clr inserts a bubble and wins over en (load).
module if_id_reg
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic [DATA_WIDTH-1:0]    instr_in,
  input  logic [ADDRESS_WIDTH-1:0] pc_in,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_in,
  output logic [DATA_WIDTH-1:0]    instr_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
  output logic                     valid_d
);

  // IF/ID contents: reset/clear to bubble, load on en, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_d    <= DATA_WIDTH'(NOP_INSTR);
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (clr) begin
      instr_d    <= DATA_WIDTH'(NOP_INSTR);
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (en) begin
      instr_d    <= instr_in;
      pc_d       <= pc_in;
      pc_plus4_d <= pc_plus4_in;
      valid_d    <= 1'b1;
    end else begin
      instr_d    <= instr_d;
      pc_d       <= pc_d;
      pc_plus4_d <= pc_plus4_d;
      valid_d    <= valid_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC register, BOOT/RUN/HALT FSM, redirect
// handling with misalignment trap, and the IF/ID register instance.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_f,
  input  logic                     stall_d,
  input  logic                     flush_d,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  output logic [ADDRESS_WIDTH-1:0] instr_addr,
  input  logic [DATA_WIDTH-1:0]    instr_f,
  output logic [DATA_WIDTH-1:0]    instr_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
  output logic                     valid_d,
  output logic                     misalign_err,
  output logic [31:0]              fetch_count
);

  logic [ADDRESS_WIDTH-1:0] pc_r;
  logic [ADDRESS_WIDTH-1:0] pc_next_s;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_s;
  logic [1:0]               state_r;
  logic [1:0]               state_next_s;
  logic                     misalign_r;
  logic                     misalign_set_s;
  logic [31:0]              fetch_count_r;
  logic                     ifid_en_s;
  logic                     ifid_clr_s;
  logic                     redirect_bad_s;

  assign pc_plus4_s     = pc_r + ADDRESS_WIDTH'(32'd4);
  assign redirect_bad_s = pc_src_e & ~word_aligned(pc_target_e[1:0]);

  // Next-state, next-PC and IF/ID control decode.
  always_comb begin
    pc_next_s      = pc_r;
    state_next_s   = state_r;
    ifid_en_s      = 1'b0;
    ifid_clr_s     = 1'b0;
    misalign_set_s = 1'b0;
    case (state_r)
      ST_BOOT: begin
        pc_next_s    = RESET_PC;
        ifid_clr_s   = 1'b1;
        state_next_s = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_bad_s) begin
          // Bad target: freeze the PC and trap until the next reset.
          misalign_set_s = 1'b1;
          ifid_clr_s     = 1'b1;
          state_next_s   = ST_HALT;
        end else begin
          if (pc_src_e) begin
            pc_next_s = pc_target_e;
          end else if (stall_f) begin
            pc_next_s = pc_r;
          end else begin
            pc_next_s = pc_plus4_s;
          end
          if (flush_d) begin
            ifid_clr_s = 1'b1;
          end else if (stall_d) begin
            ifid_en_s = 1'b0;
          end else begin
            ifid_en_s = 1'b1;
          end
        end
      end
      ST_HALT: begin
        ifid_clr_s = 1'b1;
      end
      default: begin
        pc_next_s    = RESET_PC;
        ifid_clr_s   = 1'b1;
        state_next_s = ST_BOOT;
      end
    endcase
  end

  // PC, FSM state, sticky misalignment flag and accepted-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      state_r       <= ST_BOOT;
      misalign_r    <= 1'b0;
      fetch_count_r <= 32'd0;
    end else begin
      pc_r          <= pc_next_s;
      state_r       <= state_next_s;
      misalign_r    <= misalign_r | misalign_set_s;
      fetch_count_r <= (ifid_en_s && !ifid_clr_s) ? fetch_count_r + 32'd1 : fetch_count_r;
    end
  end

  assign instr_addr   = pc_r;
  assign misalign_err = misalign_r;
  assign fetch_count  = fetch_count_r;

  if_id_reg #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .en         (ifid_en_s),
    .clr        (ifid_clr_s),
    .instr_in   (instr_f),
    .pc_in      (pc_r),
    .pc_plus4_in(pc_plus4_s),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc_plus4_d (pc_plus4_d),
    .valid_d    (valid_d)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; instruction memory returns ~addr.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] instr_addr;
  logic [31:0] instr_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int tests;
  int fails;

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .instr_addr  (instr_addr),
    .instr_f     (instr_f),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d),
    .misalign_err(misalign_err),
    .fetch_count (fetch_count)
  );

  assign instr_f = ~instr_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".addr"}, instr_addr, 32'h0000_0000);
    check({tag, ".instr"}, instr_d, 32'h0000_0013);
    check({tag, ".pc_d"}, pc_d, 32'h0000_0000);
    check({tag, ".pc4"}, pc_plus4_d, 32'h0000_0000);
    check({tag, ".valid"}, {31'd0, valid_d}, 32'd0);
    check({tag, ".mis"}, {31'd0, misalign_err}, 32'd0);
    check({tag, ".cnt"}, fetch_count, 32'd0);
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] addr, input logic [31:0] ins,
                            input logic [31:0] pcd, input logic [31:0] pc4, input logic vld,
                            input logic [31:0] cnt);
    check({tag, ".addr"}, instr_addr, addr);
    check({tag, ".instr"}, instr_d, ins);
    check({tag, ".pc_d"}, pc_d, pcd);
    check({tag, ".pc4"}, pc_plus4_d, pc4);
    check({tag, ".valid"}, {31'd0, valid_d}, {31'd0, vld});
    check({tag, ".cnt"}, fetch_count, cnt);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    pc_src_e = 1'b0;
    pc_target_e = 32'h0;
    #22;
    check_reset_vals("rst");
    rst = 1'b0;

    // Reset release and free-running fetch
    step(); check_ifid("e1", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 32'd0);
    step(); check_ifid("e2", 32'h4, 32'hFFFF_FFFF, 32'h0, 32'h4, 1'b1, 32'd1);
    step(); check_ifid("e3", 32'h8, 32'hFFFF_FFFB, 32'h4, 32'h8, 1'b1, 32'd2);
    step(); check_ifid("e4", 32'hC, 32'hFFFF_FFF7, 32'h8, 32'hC, 1'b1, 32'd3);
    step(); check_ifid("e5", 32'h10, 32'hFFFF_FFF3, 32'hC, 32'h10, 1'b1, 32'd4);

    // Full stall at PC=0x10 for three cycles
    stall_f = 1'b1; stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_ifid("stall", 32'h10, 32'hFFFF_FFF3, 32'hC, 32'h10, 1'b1, 32'd4);
    end
    stall_f = 1'b0; stall_d = 1'b0;
    step(); check_ifid("resume", 32'h14, 32'hFFFF_FFEF, 32'h10, 32'h14, 1'b1, 32'd5);

    // stall_f alone duplicates the current instruction into IF/ID
    stall_f = 1'b1;
    step(); check_ifid("dup", 32'h14, 32'hFFFF_FFEB, 32'h14, 32'h18, 1'b1, 32'd6);
    stall_f = 1'b0;
    step(); check_ifid("dup_rel", 32'h18, 32'hFFFF_FFEB, 32'h14, 32'h18, 1'b1, 32'd7);

    // Redirect beats stall_f, flush beats load
    pc_src_e = 1'b1; pc_target_e = 32'h100; flush_d = 1'b1; stall_f = 1'b1;
    step(); check_ifid("redir", 32'h100, 32'h13, 32'h0, 32'h0, 1'b0, 32'd7);
    pc_src_e = 1'b0; flush_d = 1'b0; stall_f = 1'b0;
    step(); check_ifid("redir2", 32'h104, 32'hFFFF_FEFF, 32'h100, 32'h104, 1'b1, 32'd8);

    // Wrap of PC+4 at the top of the address space
    pc_src_e = 1'b1; pc_target_e = 32'hFFFF_FFFC;
    step(); check_ifid("top", 32'hFFFF_FFFC, 32'hFFFF_FEFB, 32'h104, 32'h108, 1'b1, 32'd9);
    pc_src_e = 1'b0;
    step(); check_ifid("wrap", 32'h0, 32'h0000_0003, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'd10);
    check("wrap.mis", {31'd0, misalign_err}, 32'd0);
    step(); check_ifid("wrap2", 32'h4, 32'hFFFF_FFFF, 32'h0, 32'h4, 1'b1, 32'd11);

    // Asynchronous reset mid-cycle during a stall
    stall_f = 1'b1; stall_d = 1'b1;
    #3 rst = 1'b1;
    #1 check_reset_vals("arst");
    stall_f = 1'b0; stall_d = 1'b0;
    #2 rst = 1'b0;
    step(); check_ifid("ar1", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 32'd0);
    step(); check_ifid("ar2", 32'h4, 32'hFFFF_FFFF, 32'h0, 32'h4, 1'b1, 32'd1);
    step(); check_ifid("ar3", 32'h8, 32'hFFFF_FFFB, 32'h4, 32'h8, 1'b1, 32'd2);

    // Misaligned redirect traps into HALT
    pc_src_e = 1'b1; pc_target_e = 32'h102;
    step(); check_ifid("mis", 32'h8, 32'h13, 32'h0, 32'h0, 1'b0, 32'd2);
    check("mis.flag", {31'd0, misalign_err}, 32'd1);
    pc_target_e = 32'h200;
    for (int i = 0; i < 10; i++) begin
      stall_f = i[0];
      stall_d = i[1];
      pc_src_e = i[2];
      step(); check_ifid("halt", 32'h8, 32'h13, 32'h0, 32'h0, 1'b0, 32'd2);
      check("halt.flag", {31'd0, misalign_err}, 32'd1);
    end
    pc_src_e = 1'b0; stall_f = 1'b0; stall_d = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_vals("hrst");
    #3 rst = 1'b0;
    step(); check_ifid("hr1", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 32'd0);
    step(); check_ifid("hr2", 32'h4, 32'hFFFF_FFFF, 32'h0, 32'h4, 1'b1, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
